core_cache_bus_arbiter: RTL and testbench

CORE_CACHE_BUS_ARBITER -- requirements
Module: core_cache_bus_arbiter

---
 rtl/core_cache_bus_arbiter_pkg.sv | 35 +++
 rtl/core_cache_bus_arbiter_picker.sv | 37 +++
 rtl/core_cache_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_core_cache_bus_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_cache_bus_arbiter_pkg.sv
// Shared types for the core cache bus arbiter: bus request/response
// structs, the one-hot arbiter state and the default requester count.
package core_cache_bus_arbiter_pkg;

    localparam int N_REQ_DEFAULT = 2;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  burst_size;
        logic [31:0] w_data;
        logic        data_ok;
        logic        data_last;
    } cache_bus_req_t;

    typedef struct packed {
        logic        ready;
        logic        data_ok;
        logic        data_last;
        logic [31:0] r_data;
    } cache_bus_resp_t;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        ADDR = 3'b010,
        DATA = 3'b100
    } arb_state_e;

    // Number of beats a burst is expected to carry (burst_size is length-1).
    function automatic logic [4:0] burst_beats(input logic [3:0] burst_size);
        return {1'b0, burst_size} + 5'd1;
    endfunction

endpackage

// File: rtl/core_cache_bus_arbiter_picker.sv
// Combinational round-robin selector: returns the first valid index at or
// after prio_i, wrapping at N_REQ, plus an any-valid flag.
module core_rr_picker #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] prio_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             any_valid_o
);

    int best_dist_s;
    int dist_s;

    // Pick the valid requester with the smallest circular distance from prio.
    always_comb begin
        winner_o    = '0;
        best_dist_s = N_REQ;
        dist_s      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i >= int'(prio_i)) begin
                dist_s = i - int'(prio_i);
            end else begin
                dist_s = i + N_REQ - int'(prio_i);
            end
            if (valid_i[i] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                winner_o    = IDX_W'(i);
            end else begin
                best_dist_s = best_dist_s;
            end
        end
        any_valid_o = |valid_i;
    end

endmodule

// File: rtl/core_cache_bus_arbiter.sv
// Arbitrates the icache and dcache onto one downstream cache bus. A granted
// requester owns the bus from address phase through its last data beat;
// re-arbitration only happens from IDLE.
module core_cache_bus_arbiter
    import core_cache_bus_arbiter_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEFAULT,
    parameter int INIT_PRIO = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  cache_bus_req_t  [N_REQ-1:0]        req_i,
    output cache_bus_resp_t [N_REQ-1:0]        resp_o,
    output logic            [N_REQ-1:0]        busy_o,
    output cache_bus_req_t                     bus_req_o,
    input  cache_bus_resp_t                    bus_resp_i,
    output logic                               err_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] prio_q, prio_d;
    logic [4:0]       beat_cnt_q, beat_cnt_d;
    logic [4:0]       exp_beats_q, exp_beats_d;
    logic             err_q, err_d;

    logic [N_REQ-1:0] valid_s;
    logic [IDX_W-1:0] win_s;
    logic             any_s;
    cache_bus_req_t   gnt_req_s;
    logic             beat_s;
    logic             last_s;

    assign gnt_req_s = req_i[gnt_q];
    assign err_o     = err_q;

    // Collect the per-requester valid bits for the picker.
    always_comb begin
        valid_s = '0;
        for (int r = 0; r < N_REQ; r++) begin
            valid_s[r] = req_i[r].valid;
        end
    end

    core_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .valid_i     (valid_s),
        .prio_i      (prio_q),
        .winner_o    (win_s),
        .any_valid_o (any_s)
    );

    // Decode a data beat and its last flag; writes need both sides' data_ok.
    always_comb begin
        if (gnt_req_s.we) begin
            beat_s = gnt_req_s.data_ok && bus_resp_i.data_ok;
            last_s = gnt_req_s.data_last;
        end else begin
            beat_s = bus_resp_i.data_ok;
            last_s = bus_resp_i.data_last;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            prio_q      <= IDX_W'(INIT_PRIO);
            beat_cnt_q  <= 5'd0;
            exp_beats_q <= 5'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            prio_q      <= prio_d;
            beat_cnt_q  <= beat_cnt_d;
            exp_beats_q <= exp_beats_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, wait for address accept, count beats.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        prio_d      = prio_q;
        beat_cnt_d  = beat_cnt_q;
        exp_beats_d = exp_beats_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    state_d = ADDR;
                    gnt_d   = win_s;
                    if (int'(win_s) == N_REQ - 1) begin
                        prio_d = '0;
                    end else begin
                        prio_d = win_s + IDX_W'(1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                if (gnt_req_s.valid && bus_resp_i.ready) begin
                    state_d     = DATA;
                    beat_cnt_d  = 5'd0;
                    exp_beats_d = burst_beats(gnt_req_s.burst_size);
                end else if (!gnt_req_s.valid) begin
                    state_d = IDLE;
                end else begin
                    state_d = ADDR;
                end
            end
            DATA: begin
                if (beat_s) begin
                    beat_cnt_d = beat_cnt_q + 5'd1;
                    if (last_s) begin
                        state_d = IDLE;
                        err_d   = ((beat_cnt_q + 5'd1) != exp_beats_q);
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: route the owner's request/response, zero everything else.
    always_comb begin
        bus_req_o = '0;
        resp_o    = '0;
        busy_o    = '0;
        if (state_q != IDLE) begin
            bus_req_o     = gnt_req_s;
            resp_o[gnt_q] = bus_resp_i;
        end else begin
            bus_req_o = '0;
        end
        for (int r = 0; r < N_REQ; r++) begin
            busy_o[r] = (state_q != IDLE) && (int'(gnt_q) != r);
        end
    end

endmodule

// File: tb/tb_core_cache_bus_arbiter.sv
// Directed plus randomized bench for core_cache_bus_arbiter, checked each
// cycle against a transaction-level reference model.
module tb_core_cache_bus_arbiter;
    import core_cache_bus_arbiter_pkg::*;

    localparam int N = 2;
    localparam int INIT_P = 1;

    logic                       clk;
    logic                       rst_n;
    cache_bus_req_t  [N-1:0]    req_i;
    cache_bus_resp_t [N-1:0]    resp_o;
    logic            [N-1:0]    busy_o;
    cache_bus_req_t             bus_req_o;
    cache_bus_resp_t            bus_resp_i;
    logic                       err_o;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus and what phase the transfer is in.
    bit m_active;
    bit m_addr_phase;
    int m_owner;
    int m_prio;
    int m_beats;
    int m_expect;
    bit m_err;

    core_cache_bus_arbiter #(.N_REQ(N), .INIT_PRIO(INIT_P)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .resp_o     (resp_o),
        .busy_o     (busy_o),
        .bus_req_o  (bus_req_o),
        .bus_resp_i (bus_resp_i),
        .err_o      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model over one rising edge using the inputs in force.
    task automatic model_edge();
        bit beat;
        bit last;
        if (!rst_n) begin
            m_active = 0; m_addr_phase = 0; m_owner = 0;
            m_prio = INIT_P; m_beats = 0; m_expect = 0; m_err = 0;
        end else begin
            m_err = 0;
            if (!m_active) begin
                for (int off = 0; off < N; off++) begin
                    int cand;
                    cand = (m_prio + off) % N;
                    if (!m_active && req_i[cand].valid) begin
                        m_active = 1; m_addr_phase = 1; m_owner = cand;
                        m_prio = (cand + 1) % N;
                    end
                end
            end else if (m_addr_phase) begin
                if (req_i[m_owner].valid && bus_resp_i.ready) begin
                    m_addr_phase = 0; m_beats = 0;
                    m_expect = int'(req_i[m_owner].burst_size) + 1;
                end else if (!req_i[m_owner].valid) begin
                    m_active = 0;
                end
            end else begin
                if (req_i[m_owner].we) begin
                    beat = req_i[m_owner].data_ok && bus_resp_i.data_ok;
                    last = req_i[m_owner].data_last;
                end else begin
                    beat = bus_resp_i.data_ok;
                    last = bus_resp_i.data_last;
                end
                if (beat) begin
                    m_beats = (m_beats + 1) % 32;
                    if (last) begin
                        m_active = 0;
                        m_err = (m_beats != m_expect);
                    end
                end
            end
        end
    endtask

    // Check every output against the model, then clock one cycle.
    task automatic step();
        cache_bus_req_t  exp_req;
        cache_bus_resp_t exp_resp;
        logic [N-1:0]    exp_busy;
        #1;
        exp_req = m_active ? req_i[m_owner] : '0;
        check("bus_req", 128'(bus_req_o), 128'(exp_req));
        for (int r = 0; r < N; r++) begin
            exp_resp = (m_active && r == m_owner) ? bus_resp_i : '0;
            check($sformatf("resp%0d", r), 128'(resp_o[r]), 128'(exp_resp));
            exp_busy[r] = m_active && (r != m_owner);
        end
        check("busy", 128'(busy_o), 128'(exp_busy));
        check("err", 128'(err_o), 128'(m_err));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    function automatic cache_bus_req_t mk_req(input bit v, input bit we, input logic [31:0] a,
                                              input logic [3:0] bs, input logic [31:0] wd,
                                              input bit dok, input bit dl);
        cache_bus_req_t r;
        r.valid = v; r.we = we; r.addr = a; r.burst_size = bs;
        r.w_data = wd; r.data_ok = dok; r.data_last = dl;
        return r;
    endfunction

    // Accept the address, then return read beats with data_last on beat last_at.
    task automatic serve_read(input int beats, input int last_at);
        bus_resp_i = '0; bus_resp_i.ready = 1'b1;
        step();
        for (int b = 1; b <= beats; b++) begin
            bus_resp_i = '0;
            bus_resp_i.data_ok = 1'b1;
            bus_resp_i.data_last = (b == last_at);
            bus_resp_i.r_data = $urandom;
            step();
        end
        bus_resp_i = '0;
    endtask

    initial begin
        rst_n = 1'b0; req_i = '0; bus_resp_i = '0;
        @(posedge clk); model_edge(); @(negedge clk);
        step(); step();
        check("reset_busy", 128'(busy_o), 128'(2'b00));
        rst_n = 1'b1;
        step();

        // Contention right after reset: dcache, icache, dcache.
        req_i[0] = mk_req(1, 0, 32'h1000_0000, 4'd0, 32'h0, 0, 0);
        req_i[1] = mk_req(1, 0, 32'h2000_0000, 4'd0, 32'h0, 0, 0);
        step();
        check("cont1_gnt_dcache", 128'(busy_o), 128'(2'b01));
        serve_read(1, 1);
        step();
        check("cont2_gnt_icache", 128'(busy_o), 128'(2'b10));
        serve_read(1, 1);
        step();
        check("cont3_gnt_dcache", 128'(busy_o), 128'(2'b01));
        serve_read(1, 1);
        req_i = '0;
        step();

        // Icache 4-beat read.
        req_i[0] = mk_req(1, 0, 32'h1C00_0010, 4'd3, 32'h0, 0, 0);
        step();
        check("rd4_busy", 128'(busy_o), 128'(2'b10));
        check("rd4_addr", 128'(bus_req_o.addr), 128'(32'h1C00_0010));
        serve_read(4, 4);
        req_i = '0;
        check("rd4_idle", 128'(busy_o), 128'(2'b00));
        step();
        check("rd4_no_err", 128'(err_o), 128'(1'b0));

        // Dcache 2-beat write with downstream stall on beat 2.
        req_i[1] = mk_req(1, 1, 32'h0000_0400, 4'd1, 32'hAAAA_0001, 1, 0);
        step();
        bus_resp_i = '0; bus_resp_i.ready = 1'b1;
        step();
        bus_resp_i = '0; bus_resp_i.data_ok = 1'b1;
        step();
        req_i[1] = mk_req(1, 1, 32'h0000_0400, 4'd1, 32'hBBBB_0002, 1, 1);
        bus_resp_i = '0;
        for (int s = 0; s < 3; s++) begin
            step();
            check("wr_stall_busy", 128'(busy_o), 128'(2'b01));
            check("wr_stall_wdata", 128'(bus_req_o.w_data), 128'(32'hBBBB_0002));
        end
        bus_resp_i.data_ok = 1'b1;
        step();
        req_i = '0; bus_resp_i = '0;
        check("wr_done", 128'(busy_o), 128'(2'b00));
        check("wr_no_err", 128'(err_o), 128'(1'b0));
        step();

        // Burst length mismatch: 4 expected, last on beat 2.
        req_i[0] = mk_req(1, 0, 32'h0000_0800, 4'd3, 32'h0, 0, 0);
        step();
        serve_read(2, 2);
        req_i = '0;
        check("mm_err_pulse", 128'(err_o), 128'(1'b1));
        check("mm_idle", 128'(busy_o), 128'(2'b00));
        step();
        check("mm_err_clear", 128'(err_o), 128'(1'b0));

        // Reset during beat 2 of a read.
        req_i[0] = mk_req(1, 0, 32'h0000_0C00, 4'd3, 32'h0, 0, 0);
        step();
        bus_resp_i = '0; bus_resp_i.ready = 1'b1;
        step();
        bus_resp_i = '0; bus_resp_i.data_ok = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        check("rst_mid_busy", 128'(busy_o), 128'(2'b00));
        check("rst_mid_valid", 128'(bus_req_o.valid), 128'(1'b0));
        rst_n = 1'b1; req_i = '0; bus_resp_i = '0;
        step();

        // Icache withdraws in ADDR, pending dcache granted afterwards.
        req_i[0] = mk_req(1, 0, 32'h0000_1000, 4'd0, 32'h0, 0, 0);
        step();
        check("wd_gnt_icache", 128'(busy_o), 128'(2'b10));
        req_i[0].valid = 1'b0;
        req_i[1] = mk_req(1, 0, 32'h0000_2000, 4'd0, 32'h0, 0, 0);
        step();
        check("wd_idle", 128'(busy_o), 128'(2'b00));
        check("wd_no_err", 128'(err_o), 128'(1'b0));
        step();
        check("wd_gnt_dcache", 128'(busy_o), 128'(2'b01));
        serve_read(1, 1);
        req_i = '0;
        step();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            for (int r = 0; r < N; r++) begin
                req_i[r].valid      = ($urandom_range(0, 3) != 0);
                req_i[r].we         = 1'($urandom_range(0, 1));
                req_i[r].addr       = $urandom;
                req_i[r].burst_size = 4'($urandom_range(0, 3));
                req_i[r].w_data     = $urandom;
                req_i[r].data_ok    = 1'($urandom_range(0, 1));
                req_i[r].data_last  = ($urandom_range(0, 2) == 0);
            end
            bus_resp_i.ready     = 1'($urandom_range(0, 1));
            bus_resp_i.data_ok   = 1'($urandom_range(0, 1));
            bus_resp_i.data_last = ($urandom_range(0, 2) == 0);
            bus_resp_i.r_data    = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
